// File: rtl/iob_fifo_stream_out.sv
// ---------------------------------------------------------------------------
// iob_fifo_stream_out
//
// Drains a registered-read FIFO (data valid the cycle after the read strobe)
// into a valid/ready stream. A 2-entry buffer absorbs the read latency, so the
// stream can carry one word per cycle while the consumer keeps m_ready high.
// Packet boundaries are flagged on m_last from a programmable beat count.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   en           1: issue FIFO reads; 0: issue no new reads, drain held words
//   pkt_len      beats per packet; 0 = never assert m_last
//   fifo_empty   FIFO empty flag
//   fifo_read_en FIFO read strobe
//   fifo_data    FIFO read data, valid the cycle after fifo_read_en
//   m_valid      stream word valid
//   m_ready      stream consumer ready
//   m_data       stream word (buffer head)
//   m_last       last beat of the current packet
//   beat_cnt     beats accepted so far in the current packet
// ---------------------------------------------------------------------------
module iob_fifo_stream_out #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic              fifo_empty,
   output logic              fifo_read_en,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [LEN_W-1:0]  beat_cnt
);

   // Buffer slot 0 is always the head; slot 1 holds the second word.
   logic [DATA_W-1:0] buf_q [2];
   logic [1:0]        occ_q;        // words held in the buffer, 0..2
   logic              inflight_q;   // a read was issued last cycle
   logic [LEN_W-1:0]  beat_cnt_q;

   logic              accept;
   logic [1:0]        held_after;   // words held or in flight once this cycle's beat leaves
   logic [1:0]        wr_slot;      // buffer slot the in-flight word lands in
   logic              last_hit;

   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      accept       = (occ_q != 2'd0) & m_ready;
      held_after   = occ_q + {1'b0, inflight_q} - {1'b0, accept};
      wr_slot      = occ_q - {1'b0, accept};
      // Gated by rst so no read is issued while reset is held.
      fifo_read_en = ~rst & en & ~fifo_empty & (held_after < 2'd2);
      last_hit     = (pkt_len != '0) & (beat_cnt_q == pkt_len - LEN_W'(1));
   end

   assign m_valid  = (occ_q != 2'd0);
   assign m_data   = buf_q[0];
   assign m_last   = m_valid & last_hit;
   assign beat_cnt = beat_cnt_q;

   // NOTE: the two buffer words are reset as well, because m_data reads the head
   // directly and must show 0 while in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         beat_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every update based on pre-edge values,
         // which the shift-then-write below relies on.
         inflight_q <= fifo_read_en;
         occ_q      <= held_after;

         // Pop shifts the second word forward; a capture in the same cycle lands in
         // the slot computed after the pop and overrides the shift when it is slot 0.
         if (accept)
            buf_q[0] <= buf_q[1];
         if (inflight_q)
            buf_q[wr_slot[0]] <= fifo_data;

         if (accept)
            beat_cnt_q <= m_last ? '0 : beat_cnt_q + LEN_W'(1);
      end
   end

   // The read-issue rule keeps held plus in-flight words at two or fewer.
   always @(posedge clk) begin
      if (!rst)
         a_no_overflow: assert (({1'b0, occ_q} + {2'b0, inflight_q}) <= 3'd2);
   end

endmodule

// File: tb/tb_iob_fifo_stream_out.sv
// ---------------------------------------------------------------------------
// Bench for iob_fifo_stream_out. A behavioural registered-read FIFO feeds the
// DUT; an in-order queue of pushed words plus a count of accepted beats since
// reset gives the expected data, beat_cnt and m_last of every accepted beat.
// ---------------------------------------------------------------------------
module tb_iob_fifo_stream_out;

   localparam int DATA_W = 8;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [LEN_W-1:0]  pkt_len;
   logic              fifo_empty;
   logic              fifo_read_en;
   logic [DATA_W-1:0] fifo_data = '0;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic [LEN_W-1:0]  beat_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   iob_fifo_stream_out #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .pkt_len      (pkt_len),
      .fifo_empty   (fifo_empty),
      .fifo_read_en (fifo_read_en),
      .fifo_data    (fifo_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .beat_cnt     (beat_cnt)
   );

   // ---------------- behavioural FIFO with registered read ----------------
   logic [DATA_W-1:0] fmem [0:255];
   int                wp = 0;
   int                rp = 0;
   logic              push_req = 1'b0;
   logic [DATA_W-1:0] push_data = '0;
   logic              flush = 1'b0;

   always @(posedge clk) begin
      if (flush) begin
         wp <= 0;
         rp <= 0;
      end else begin
         if (push_req) begin
            fmem[wp % 256] <= push_data;
            wp <= wp + 1;
         end
         if (fifo_read_en) begin
            fifo_data <= fmem[rp % 256];
            rp <= rp + 1;
         end
      end
   end
   assign fifo_empty = (wp == rp);

   // ---------------- reference model state ----------------
   logic [DATA_W-1:0] exp_q [$];
   int                beat_idx;   // beats accepted since reset
   int                reads;
   int                accepts;
   int                held;       // words read but not yet accepted
   logic              acc;
   logic [DATA_W-1:0] exp_data;
   logic [LEN_W-1:0]  exp_cnt;
   logic              exp_last;

   // Drive one cycle of inputs on the falling edge, sample just after, and
   // work out what the rising edge will accept.
   task automatic step(input logic psh, input logic [DATA_W-1:0] d,
                       input logic rdy, input logic e);
      @(negedge clk);
      push_req  = psh;
      push_data = d;
      m_ready   = rdy;
      en        = e;
      if (psh) exp_q.push_back(d);
      #1;
      acc = m_valid && m_ready;
      if (fifo_read_en) reads++;
      if (acc) begin
         if (exp_q.size() > 0) exp_data = exp_q.pop_front();
         else                  exp_data = 'x;
         if (pkt_len == 0) exp_cnt = LEN_W'(beat_idx);
         else              exp_cnt = LEN_W'(beat_idx % int'(pkt_len));
         exp_last = (pkt_len != 0) && (int'(exp_cnt) == int'(pkt_len) - 1);
         beat_idx++;
         accepts++;
      end
      held = reads - accepts;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; flush = 1'b1; push_req = 1'b0; en = 1'b0; m_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b0; rst = 1'b0;
      exp_q.delete();
      beat_idx = 0; reads = 0; accepts = 0; held = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      pkt_len = '0;
      for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(8'h11 + i), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)  step(1'b0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)  step(1'b0, '0, 1'b0, 1'b1);
      // Reset asserted between clock edges.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
      total++; if (m_data !== '0) begin bad++; $display("FAIL reset_m_data got=%h want=00", m_data); end
      total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b want=0", m_last); end
      total++; if (beat_cnt !== '0) begin bad++; $display("FAIL reset_beat_cnt got=%0d want=0", beat_cnt); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en = 1'b1;
         #1;
         total++;
         if (fifo_read_en !== 1'b0 || fifo_empty !== 1'b0) begin
            bad++; $display("FAIL reset_no_read read_en=%b fifo_empty=%b want 0/0", fifo_read_en, fifo_empty);
         end
      end
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0; rst = 1'b0; en = 1'b0;
      exp_q.delete();
      beat_idx = 0; reads = 0; accepts = 0; held = 0;
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_after_release m_valid got=%b want=0", m_valid); end
   endtask

   task automatic test_stream();
      int first_c = -1;
      int last_c  = -1;
      do_reset();
      pkt_len = 16'd4;
      for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0);
      for (int c = 0; c < 40 && accepts < 16; c++) begin
         step(1'b0, '0, 1'b1, 1'b1);
         if (acc) begin
            total++; if (m_data !== exp_data) begin bad++; $display("FAIL stream_data got=%h want=%h", m_data, exp_data); end
            total++; if (m_last !== exp_last) begin bad++; $display("FAIL stream_last beat=%0d got=%b want=%b", beat_idx-1, m_last, exp_last); end
            total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL stream_beat_cnt got=%0d want=%0d", beat_cnt, exp_cnt); end
            if (first_c < 0) first_c = c;
            last_c = c;
         end
      end
      total++; if (accepts != 16) begin bad++; $display("FAIL stream_count got=%0d want=16", accepts); end
      total++; if (last_c - first_c != 15) begin bad++; $display("FAIL stream_back_to_back span got=%0d want=15", last_c - first_c); end
   endtask

   // Random pushes and ready pattern; mode 0 uses ready 1,0,0,1 repeating.
   task automatic run_random(input logic [LEN_W-1:0] len, input int nwords, input int mode);
      int                pushed = 0;
      logic              prev_stall = 1'b0;
      logic [DATA_W-1:0] prev_data = '0;
      logic              psh;
      logic              rdy;
      do_reset();
      pkt_len = len;
      for (int c = 0; c < 1000 && (pushed < nwords || accepts < nwords); c++) begin
         psh = (pushed < nwords) && ($urandom_range(0, 3) != 0);
         rdy = (mode == 0) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'($urandom_range(0, 1));
         step(psh, DATA_W'($urandom), rdy, 1'b1);
         if (psh) pushed++;
         if (prev_stall) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
               bad++; $display("FAIL stall_stable valid=%b data=%h want 1/%h", m_valid, m_data, prev_data);
            end
         end
         if (!m_valid) begin
            total++; if (m_last !== 1'b0) begin bad++; $display("FAIL last_without_valid got=%b want=0", m_last); end
         end
         if (acc) begin
            total++; if (m_data !== exp_data) begin bad++; $display("FAIL rand_data len=%0d got=%h want=%h", len, m_data, exp_data); end
            total++; if (m_last !== exp_last) begin bad++; $display("FAIL rand_last len=%0d got=%b want=%b", len, m_last, exp_last); end
            total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL rand_beat_cnt len=%0d got=%0d want=%0d", len, beat_cnt, exp_cnt); end
         end
         total++; if (held > 2) begin bad++; $display("FAIL overflow held=%0d want<=2", held); end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
      total++; if (accepts != nwords) begin bad++; $display("FAIL rand_count len=%0d got=%0d want=%0d", len, accepts, nwords); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      run_random(16'($urandom_range(2, 6)), 60, 0);
      run_random(16'd3, 60, 1);
   endtask

   task automatic test_pkt_len_edges();
      run_random(16'd0, 40, 1);
      run_random(16'd1, 40, 1);
   endtask

   task automatic test_latency();
      int  fall = -1;
      int  rise = -1;
      logic after_done = 1'b0;
      do_reset();
      pkt_len = 16'd1;
      step(1'b1, 8'hA5, 1'b1, 1'b1);
      for (int c = 1; c < 12; c++) begin
         step(1'b0, '0, 1'b1, 1'b1);
         if (rise >= 0 && c == rise + 1) begin
            after_done = 1'b1;
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL latency_drop m_valid got=%b want=0", m_valid); end
         end
         if (fall < 0 && !fifo_empty) fall = c;
         if (rise < 0 && m_valid) begin
            rise = c;
            total++; if (m_data !== 8'hA5) begin bad++; $display("FAIL latency_data got=%h want=a5", m_data); end
            total++; if (m_last !== 1'b1) begin bad++; $display("FAIL latency_last got=%b want=1", m_last); end
         end
      end
      total++;
      if (fall < 0 || rise < 0 || rise - fall != 2 || !after_done) begin
         bad++; $display("FAIL latency_cycles got=%0d want=2 (fall=%0d rise=%0d)", rise - fall, fall, rise);
      end
   endtask

   task automatic test_enable();
      int rem;
      int fcount;
      int beats;
      for (int scen = 0; scen < 2; scen++) begin
         do_reset();
         pkt_len = '0;
         for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(i + 1), 1'b1, 1'b0);
         if (scen == 0) for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
         else           for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
         step(1'b0, '0, (scen == 0), 1'b0);
         if (acc) begin
            total++; if (m_data !== exp_data) begin bad++; $display("FAIL enable_data got=%h want=%h", m_data, exp_data); end
         end
         rem    = held;
         fcount = wp - rp;
         if (scen == 1) begin
            total++; if (rem != 2) begin bad++; $display("FAIL enable_held got=%0d want=2", rem); end
         end
         beats = 0;
         for (int c = 0; c < 10; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (fifo_read_en !== 1'b0) begin bad++; $display("FAIL enable_read got=%b want=0", fifo_read_en); end
            if (!m_valid) break;
            if (acc) begin
               beats++;
               total++; if (m_data !== exp_data) begin bad++; $display("FAIL enable_data got=%h want=%h", m_data, exp_data); end
            end
         end
         total++; if (beats != rem) begin bad++; $display("FAIL enable_beats scen=%0d got=%0d want=%0d", scen, beats, rem); end
         total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL enable_idle m_valid got=%b want=0", m_valid); end
         total++; if (wp - rp != fcount) begin bad++; $display("FAIL enable_fifo_occ got=%0d want=%0d", wp - rp, fcount); end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; m_ready = 1'b0; pkt_len = '0;
      beat_idx = 0; reads = 0; accepts = 0; held = 0;
      acc = 1'b0; exp_data = '0; exp_cnt = '0; exp_last = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_pkt_len_edges();
      test_latency();
      test_enable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
